// File: rtl/keys_pkg.sv
// keys_pkg: shared definitions for the key conditioner.
//   - key_state_e : per-channel debounce state encoding
//   - DEF_*       : default timing/config constants (50 MHz board clock)
//   - clog2/max2  : constant helpers for counter sizing
package keys_pkg;

  typedef enum logic [1:0] {
    KEY_RELEASED    = 2'd0,
    KEY_PRESS_CHK   = 2'd1,
    KEY_PRESSED     = 2'd2,
    KEY_RELEASE_CHK = 2'd3
  } key_state_e;

  localparam int unsigned DEF_NUM_KEYS       = 4;
  localparam int unsigned DEF_DEB_CYCLES     = 500000;
  localparam bit          DEF_KEY_ACTIVE_LOW = 1'b1;
  localparam int unsigned DEF_REPEAT_DELAY   = 25000000;
  localparam int unsigned DEF_REPEAT_RATE    = 5000000;

  // Bits needed to hold values 0..value-1; never less than 1.
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned width;
    width = 1;
    for (int unsigned i = 1; i < 32; i++) begin
      if ((32'd1 << i) < value) width = i + 1;
    end
    return width;
  endfunction

  function automatic int unsigned max2(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/keys_conditioner_if.sv
// keys_conditioner_if: key bus between board pins, the conditioner and its consumer.
//   keys_in      : raw button pins
//   keys_out     : debounced level, 1 = pressed
//   keys_press   : one-cycle press pulse per key
//   keys_release : one-cycle release pulse per key
// Modports: master = pin driver / consumer side, slave = conditioner side.
import keys_pkg::*;

interface keys_conditioner_if #(
  parameter int unsigned NUM_KEYS = DEF_NUM_KEYS
);
  logic [NUM_KEYS-1:0] keys_in;
  logic [NUM_KEYS-1:0] keys_out;
  logic [NUM_KEYS-1:0] keys_press;
  logic [NUM_KEYS-1:0] keys_release;

  modport master (
    output keys_in,
    input  keys_out,
    input  keys_press,
    input  keys_release
  );

  modport slave (
    input  keys_in,
    output keys_out,
    output keys_press,
    output keys_release
  );
endinterface

// File: rtl/key_debounce_ch.sv
// key_debounce_ch: one key channel -- 2-FF synchroniser, 4-state debounce FSM
// with stability counter, registered level and press/release pulses.
// Optional auto-repeat press pulses when KEYS_AUTOREPEAT_EN is defined.
// Ports:
//   clk, reset   : board clock, synchronous active-high reset
//   pin_in       : raw asynchronous button pin
//   level_out    : debounced level, 1 = pressed
//   press_out    : one-cycle pulse on accepted press (and auto-repeat)
//   release_out  : one-cycle pulse on accepted release
module key_debounce_ch
  import keys_pkg::*;
#(
  parameter int unsigned DEB_CYCLES     = DEF_DEB_CYCLES,
  parameter bit          KEY_ACTIVE_LOW = DEF_KEY_ACTIVE_LOW,
  parameter int unsigned REPEAT_DELAY   = DEF_REPEAT_DELAY,
  parameter int unsigned REPEAT_RATE    = DEF_REPEAT_RATE
) (
  input  logic clk,
  input  logic reset,
  input  logic pin_in,
  output logic level_out,
  output logic press_out,
  output logic release_out
);

  localparam int unsigned    CNT_W    = clog2(DEB_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);

  logic [1:0]       sync_q, sync_d;
  key_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             level_q, level_d;
  logic             press_q, press_d;
  logic             release_q, release_d;
  logic             raw;
  logic             rep_fire;

  // Normalised so that raw = 1 always means "pressed".
  assign raw = sync_q[1] ^ KEY_ACTIVE_LOW;

  always_comb begin
    sync_d    = {sync_q[0], pin_in};
    state_d   = state_q;
    cnt_d     = cnt_q;
    level_d   = level_q;
    press_d   = 1'b0;
    release_d = 1'b0;
    case (state_q)
      KEY_RELEASED: begin
        if (raw) begin
          state_d = KEY_PRESS_CHK;
          cnt_d   = '0;
        end
      end
      KEY_PRESS_CHK: begin
        if (!raw) begin
          state_d = KEY_RELEASED;
        end else if (cnt_q == CNT_LAST) begin
          state_d = KEY_PRESSED;
          level_d = 1'b1;
          press_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      KEY_PRESSED: begin
        if (!raw) begin
          state_d = KEY_RELEASE_CHK;
          cnt_d   = '0;
        end
      end
      KEY_RELEASE_CHK: begin
        if (raw) begin
          state_d = KEY_PRESSED;
        end else if (cnt_q == CNT_LAST) begin
          state_d   = KEY_RELEASED;
          level_d   = 1'b0;
          release_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = KEY_RELEASED;
    endcase
    press_d = press_d | rep_fire;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q    <= {2{KEY_ACTIVE_LOW}};
      state_q   <= KEY_RELEASED;
      cnt_q     <= '0;
      level_q   <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
    end else begin
      sync_q    <= sync_d;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      level_q   <= level_d;
      press_q   <= press_d;
      release_q <= release_d;
    end
  end

`ifdef KEYS_AUTOREPEAT_EN
  localparam int unsigned REP_W = clog2(max2(REPEAT_DELAY, REPEAT_RATE));

  logic [REP_W-1:0] rep_cnt_q, rep_cnt_d;
  logic             rep_armed_q, rep_armed_d;

  // Counter only advances while the key stays in PRESSED; any other cycle
  // (including the accepting edge and re-entry from RELEASE_CHK) clears it,
  // so each PRESSED stretch restarts with the initial delay.
  always_comb begin
    rep_cnt_d   = '0;
    rep_armed_d = 1'b0;
    rep_fire    = 1'b0;
    if (state_q == KEY_PRESSED && raw) begin
      rep_armed_d = rep_armed_q;
      if (!rep_armed_q && rep_cnt_q == REP_W'(REPEAT_DELAY - 1)) begin
        rep_fire    = 1'b1;
        rep_armed_d = 1'b1;
      end else if (rep_armed_q && rep_cnt_q == REP_W'(REPEAT_RATE - 1)) begin
        rep_fire = 1'b1;
      end else begin
        rep_cnt_d = rep_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rep_cnt_q   <= '0;
      rep_armed_q <= 1'b0;
    end else begin
      rep_cnt_q   <= rep_cnt_d;
      rep_armed_q <= rep_armed_d;
    end
  end
`else
  always_comb rep_fire = 1'b0;
`endif

  assign level_out   = level_q;
  assign press_out   = press_q;
  assign release_out = release_q;

endmodule

// File: rtl/keys_conditioner.sv
// keys_conditioner: debounces NUM_KEYS raw push-buttons into clean levels
// plus one-cycle press/release pulses; runs on the undivided board clock.
// Ports:
//   clk   : board clock
//   reset : synchronous, active-high reset
//   keys  : keys_conditioner_if.slave (keys_in in; keys_out, keys_press,
//           keys_release out; bit 0 = left, bit 1 = right downstream)
// Optional feature macro: KEYS_AUTOREPEAT_EN (auto-repeat press pulses).
module keys_conditioner
  import keys_pkg::*;
#(
  parameter int unsigned NUM_KEYS       = DEF_NUM_KEYS,
  parameter int unsigned DEB_CYCLES     = DEF_DEB_CYCLES,
  parameter bit          KEY_ACTIVE_LOW = DEF_KEY_ACTIVE_LOW,
  parameter int unsigned REPEAT_DELAY   = DEF_REPEAT_DELAY,
  parameter int unsigned REPEAT_RATE    = DEF_REPEAT_RATE
) (
  input  logic                clk,
  input  logic                reset,
  keys_conditioner_if.slave   keys
);

  logic [NUM_KEYS-1:0] level_vec;
  logic [NUM_KEYS-1:0] press_vec;
  logic [NUM_KEYS-1:0] release_vec;

  for (genvar i = 0; i < NUM_KEYS; i++) begin : g_ch
    key_debounce_ch #(
      .DEB_CYCLES     (DEB_CYCLES),
      .KEY_ACTIVE_LOW (KEY_ACTIVE_LOW),
      .REPEAT_DELAY   (REPEAT_DELAY),
      .REPEAT_RATE    (REPEAT_RATE)
    ) u_ch (
      .clk         (clk),
      .reset       (reset),
      .pin_in      (keys.keys_in[i]),
      .level_out   (level_vec[i]),
      .press_out   (press_vec[i]),
      .release_out (release_vec[i])
    );
  end

  assign keys.keys_out     = level_vec;
  assign keys.keys_press   = press_vec;
  assign keys.keys_release = release_vec;

endmodule

// File: tb/tb_keys_conditioner.sv
// tb_keys_conditioner: scoreboard bench for keys_conditioner.
// A reference model expressed as "a level flips once the synchronised pin has
// disagreed with it for DEB+1 consecutive samples" pushes the expected
// outputs for every clock edge; a monitor pops and compares on the falling edge.
module tb_keys_conditioner;
  localparam int unsigned NK  = 4;
  localparam int unsigned DEB = 4;
  localparam int unsigned RD  = 20;
  localparam int unsigned RR  = 6;
  localparam bit          AL  = 1'b1;

  typedef struct packed {
    logic [NK-1:0] lvl;
    logic [NK-1:0] prs;
    logic [NK-1:0] rel;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  keys_conditioner_if #(.NUM_KEYS(NK)) bus ();

  keys_conditioner #(
    .NUM_KEYS       (NK),
    .DEB_CYCLES     (DEB),
    .KEY_ACTIVE_LOW (AL),
    .REPEAT_DELAY   (RD),
    .REPEAT_RATE    (RR)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .keys  (bus)
  );

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;

  // Model state: pin delay line (synchroniser latency), accepted level,
  // length of the current disagreeing run, cycles held since acceptance.
  bit          pipe0 [NK];
  bit          pipe1 [NK];
  bit          lvl   [NK];
  int unsigned run   [NK];
  int unsigned age   [NK];

  initial begin : model
    exp_t e;
    bit   raw;
    forever begin
      @(posedge clk);
      e = '0;
      for (int k = 0; k < NK; k++) begin
        if (reset) begin
          pipe0[k] = 1'b0;
          pipe1[k] = 1'b0;
          lvl[k]   = 1'b0;
          run[k]   = 0;
          age[k]   = 0;
        end else begin
          raw      = pipe1[k];
          pipe1[k] = pipe0[k];
          pipe0[k] = bus.keys_in[k] ^ AL;
          if (raw != lvl[k]) begin
            run[k]++;
            if (run[k] == DEB + 1) begin
              lvl[k]   = raw;
              run[k]   = 0;
              age[k]   = 0;
              e.prs[k] = raw;
              e.rel[k] = !raw;
            end
          end else begin
            if (run[k] != 0) begin
              age[k] = 0;
            end else if (lvl[k]) begin
              age[k]++;
`ifdef KEYS_AUTOREPEAT_EN
              if (age[k] == RD || (age[k] > RD && (age[k] - RD) % RR == 0))
                e.prs[k] = 1'b1;
`endif
            end
            run[k] = 0;
          end
        end
        e.lvl[k] = lvl[k];
      end
      exp_q.push_back(e);
    end
  end

  task automatic chk(input string name, input logic [NK-1:0] got, input logic [NK-1:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s t=%0t got=%b expected=%b", name, $time, got, want);
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("keys_out",     bus.keys_out,     e.lvl);
        chk("keys_press",   bus.keys_press,   e.prs);
        chk("keys_release", bus.keys_release, e.rel);
      end
    end
  end

  task automatic cycles(input int unsigned n);
    repeat (n) @(negedge clk);
  endtask

  initial begin : driver
    reset       = 1'b1;
    bus.keys_in = '1;
    cycles(3);
    reset = 1'b0;
    cycles(20);
    // clean press on key 0
    bus.keys_in = 4'b1110;
    cycles(12);
    // bouncing key 1 never accepted
    repeat (5) begin
      bus.keys_in[1] = 1'b0;
      cycles(3);
      bus.keys_in[1] = 1'b1;
      cycles(1);
    end
    // release key 0
    bus.keys_in[0] = 1'b1;
    cycles(12);
    // simultaneous press, then reset while held
    bus.keys_in = 4'b1100;
    cycles(10);
    reset = 1'b1;
    cycles(2);
    reset = 1'b0;
    cycles(12);
    bus.keys_in = '1;
    cycles(12);
    // long hold on key 2
    bus.keys_in = 4'b1011;
    cycles(45);
    bus.keys_in = '1;
    cycles(12);
    // fast random bouncing with occasional reset
    repeat (400) begin
      for (int k = 0; k < NK; k++)
        if ($urandom_range(0, 3) == 0) bus.keys_in[k] = ~bus.keys_in[k];
      reset = ($urandom_range(0, 149) == 0);
      cycles(1);
    end
    reset = 1'b0;
    // slow random toggling: long holds exercise acceptance and repeats
    repeat (400) begin
      for (int k = 0; k < NK; k++)
        if ($urandom_range(0, 29) == 0) bus.keys_in[k] = ~bus.keys_in[k];
      cycles(1);
    end
    bus.keys_in = '1;
    cycles(15);
    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
